// File: rtl/data_mem_sync.sv
// Byte-addressed, big-endian data memory for the MEM stage: registered loads with a
// valid strobe, error strobe for bad requests, and a post-reset zero-fill sequence.
module data_mem_sync #(
  parameter int unsigned DEPTH_BYTES    = 1024,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] read_data,
  output logic        read_valid,
  output logic        err,
  output logic        busy
);

  localparam int unsigned WORDS = DEPTH_BYTES / 4;
  localparam int unsigned IW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned BW    = $clog2(DEPTH_BYTES);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  logic [31:0]   r_mem [WORDS];
  logic [0:0]    r_state;
  logic [IW-1:0] r_clr_idx;
  logic [31:0]   r_read_data;
  logic          r_read_valid;
  logic          r_err;

  logic [IW-1:0] w_idx;
  logic          w_oob;
  logic          w_misalign;
  logic          w_bad;
  logic          w_active;
  logic          w_wr_ok;
  logic          w_rd_ok;
  logic          w_err;
  logic [3:0]    w_be;
  logic [31:0]   w_lane;
  logic [31:0]   w_word;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_load;

  assign w_idx = addr[IW+1:2];
  assign w_oob = (addr >> BW) != '0;

  always_comb begin
    w_misalign = 1'b0;
    case (size)
      SZ_HALF: w_misalign = addr[0];
      SZ_WORD: w_misalign = addr[1:0] != 2'b00;
      default: w_misalign = 1'b0;
    endcase
  end

  assign w_bad    = (size == 2'b11) | w_misalign | w_oob;
  assign w_active = (r_state == ST_IDLE) & ~rst;
  assign w_wr_ok  = w_active & mem_write & ~w_bad;
  assign w_rd_ok  = w_active & mem_read & ~w_bad;
  assign w_err    = w_active & (mem_read | mem_write) & w_bad;

  // Lane 3 holds the lowest address (big-endian); store data is replicated across lanes.
  always_comb begin
    w_be   = 4'b0000;
    w_lane = write_data;
    case (size)
      SZ_BYTE: begin
        w_be   = 4'b1000 >> addr[1:0];
        w_lane = {4{write_data[7:0]}};
      end
      SZ_HALF: begin
        w_be   = addr[1] ? 4'b0011 : 4'b1100;
        w_lane = {2{write_data[15:0]}};
      end
      SZ_WORD: begin
        w_be   = 4'b1111;
        w_lane = write_data;
      end
      default: begin
        w_be   = 4'b0000;
        w_lane = write_data;
      end
    endcase
  end

  always_comb begin
    w_word = r_mem[w_idx];
    w_byte = 8'h00;
    case (addr[1:0])
      2'b00:   w_byte = w_word[31:24];
      2'b01:   w_byte = w_word[23:16];
      2'b10:   w_byte = w_word[15:8];
      default: w_byte = w_word[7:0];
    endcase
    w_half = addr[1] ? w_word[15:0] : w_word[31:16];
    case (size)
      SZ_BYTE: w_load = {{24{sign_ext & w_byte[7]}}, w_byte};
      SZ_HALF: w_load = {{16{sign_ext & w_half[15]}}, w_half};
      default: w_load = w_word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      r_clr_idx <= '0;
    end else if (r_state == ST_CLEAR) begin
      if (r_clr_idx == LAST_IDX) begin
        r_state <= ST_IDLE;
      end
      r_clr_idx <= r_clr_idx + IW'(1);
    end
  end

  // The load path samples the pre-edge word, so a same-cycle store is read-first.
  always_ff @(posedge clk) begin
    if (!rst && r_state == ST_CLEAR) begin
      r_mem[r_clr_idx] <= '0;
    end else if (w_wr_ok) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_lane[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_read_data  <= '0;
      r_read_valid <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_read_valid <= w_rd_ok;
      r_err        <= w_err;
      if (w_rd_ok) begin
        r_read_data <= w_load;
      end
    end
  end

  assign read_data  = r_read_data;
  assign read_valid = r_read_valid;
  assign err        = r_err;
  assign busy       = (r_state == ST_CLEAR);

endmodule
